dds_cal_engine: RTL and testbench
=================================

# dds_cal_engine

Closed-loop calibration engine that produces the gain/offset/enable control set consumed by the DA adjust stage. It captures a window of loopback samples from the ADC monitor path and tracks their minimum and maximum. It then computes the gain (sequential divider) and offset (sequential multiplier) that map the measured span onto a register-programmed target span. Results are published atomically, and the engine sits between the register file and the DA adjust stage's control inputs.

## Interface
- `DW`, 14: sample, gain and offset width (unsigned, offset-binary samples)
- `CNT_W`, 16: sample-window counter width
- `clk` in 1: system clock
- `rst` in 1: reset, asynchronous, active-low
- `cal_start` in 1: single-cycle pulse, starts a calibration run
- `cal_abort` in 1: single-cycle pulse, cancels a run in progress
- `reg_cal_samples` in CNT_W: number of valid samples per window, sampled at start
- `reg_cal_target_min` in DW: desired output minimum, sampled at start
- `reg_cal_target_max` in DW: desired output maximum, sampled at start
- `adc_data_in` in DW: loopback sample
- `adc_data_in_vld` in 1: sample qualifier
- `cal_gain` out DW: gain, unsigned Q1.13 (0x2000 = 1.0)
- `cal_offset` out DW: offset, unsigned
- `cal_en` out 1: high once at least one run has completed successfully
- `cal_busy` out 1: high in any state other than IDLE
- `cal_done` out 1: one-cycle pulse, a successful run has published results
- `cal_err` out 1: sticky; set on a failed run, cleared by the next `cal_start`

## Operation
- States: IDLE, MEASURE, DIV, MUL, APPLY.
- IDLE -> MEASURE on `cal_start`:
  - latch `reg_*` inputs;
  - clear `cal_err`;
  - init min=0x3FFF, max=0x0000, count=0.
- Start is rejected (stay IDLE, `cal_err`=1) if `reg_cal_samples`==0 or target_max<=target_min.
- MEASURE: each cycle with `adc_data_in_vld`=1:
  - update min/max with that sample;
  - increment count.
  - On the sample that makes count==N, go to DIV; that sample is included.
- DIV:
  - S = max−min (14 b); T = tmax−tmin (14 b).
  - If S==0: `cal_err`=1, go to IDLE, outputs unchanged.
  - Otherwise run a restoring divide of numerator T<<13 (27 b) by S: 1 quotient bit/cycle, exactly 27 cycles.
  - gain = min(quotient, 0x3FFF).
- MUL:
  - shift-add multiply P = min × gain (28 b), exactly 14 cycles.
  - off = tmin − (P>>13), evaluated signed at 16 b, clamped to [0, 0x3FFF].
- APPLY (1 cycle):
  - `cal_gain`, `cal_offset` registered together;
  - `cal_en`=1, `cal_done`=1; then go to IDLE.
- `cal_abort` in any non-IDLE state: go to IDLE next cycle.
  - No output update, no `cal_done`, no `cal_err`.
  - Abort has priority over all other transitions in the same cycle.
- `cal_start` while `cal_busy`=1 is ignored.
- `cal_start` and `cal_abort` together in IDLE: the start wins, since abort only acts outside IDLE.
- Previously published `cal_gain`/`cal_offset`/`cal_en` hold through failed or aborted runs.

## Timing
- Reset values:
  - `cal_gain`=0x2000, `cal_offset`=0, `cal_en`=0;
  - `cal_busy`=0, `cal_done`=0, `cal_err`=0;
  - state IDLE.
- Reset mid-run: immediate return to reset values; the run is lost.
- `cal_busy` rises on the clock edge after `cal_start`.
- The final sample is accepted at edge k:
  - DIV occupies cycles k+1..k+27;
  - MUL occupies k+28..k+41;
  - `cal_done` and the new outputs are visible from edge k+42.
  - `cal_busy` falls at k+43.
- S==0 error: `cal_err` rises and `cal_busy` falls at edge k+1.
- Rejected start: `cal_err` rises at the edge after `cal_start`; `cal_busy` stays 0.
- Samples with vld=0 are not counted. MEASURE has no timeout.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Unity run: N=4, samples 1000, 9000, 5000, 3000; target 2000..10000 -> gain 0x2000, offset 1000, `cal_done` at k+42, `cal_en`=1.
- Gain 1.5: samples 4000, 8000 (N=2); target 7000..13000 -> gain 0x3000, offset 1000.
- Saturation/clamp: samples 4000, 8000; target 0..8000 -> gain 0x3FFF, offset 0.
- Error path: N=3, all samples 5000 -> `cal_err`=1 at k+1, no `cal_done`, outputs keep prior values. A subsequent `cal_start` clears `cal_err`.
- Gaps and abort:
  - Run N=8 with vld toggling every other cycle -> completes only after 8 valid samples.
  - Repeat with `cal_abort` at DIV cycle 10 -> IDLE next cycle, no output change.
  - Repeat with `cal_start` mid-run -> ignored.
- Reset: deassert `rst` during MUL -> all outputs at reset values asynchronously. After release, a fresh unity run succeeds.

Source files
------------

// File: rtl/dds_cal_engine.sv
// dds_cal_engine: closed-loop calibration engine for the DA adjust stage.
// It measures the min/max of a window of loopback ADC samples. It then
// derives a gain (restoring divide) and an offset (shift-add multiply) that
// map the measured span onto a programmed target span. Results are
// published atomically.
// Ports:
//   clk, rst (async, active-low)
//   cal_start / cal_abort             : run control pulses
//   reg_cal_samples / reg_cal_target_* : run configuration, latched at start
//   adc_data_in / adc_data_in_vld     : loopback samples
//   cal_gain (Q1.13), cal_offset, cal_en : published control set
//   cal_busy, cal_done, cal_err       : status
module dds_cal_engine #(
  parameter int unsigned DW    = 14,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cal_start,
  input  logic             cal_abort,
  input  logic [CNT_W-1:0] reg_cal_samples,
  input  logic [DW-1:0]    reg_cal_target_min,
  input  logic [DW-1:0]    reg_cal_target_max,
  input  logic [DW-1:0]    adc_data_in,
  input  logic             adc_data_in_vld,
  output logic [DW-1:0]    cal_gain,
  output logic [DW-1:0]    cal_offset,
  output logic             cal_en,
  output logic             cal_busy,
  output logic             cal_done,
  output logic             cal_err
);

  localparam int unsigned FRAC_W = DW - 1;          // gain fraction bits
  localparam int unsigned NUM_W  = DW + FRAC_W;     // divide numerator width
  localparam int unsigned PROD_W = 2 * DW;          // product width
  localparam int unsigned STEP_W = $clog2(NUM_W);   // iteration counter width
  localparam int unsigned OFF_W  = DW + 2;          // signed offset workspace
  localparam logic [DW-1:0] GAIN_ONE = {1'b1, {FRAC_W{1'b0}}};
  localparam logic [DW-1:0] DW_MAX   = {DW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_MEASURE, S_DIV, S_MUL, S_APPLY
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    n_q, n_d, cnt_q, cnt_d;
  logic [DW-1:0]       tmin_q, tmin_d, tspan_q, tspan_d;
  logic [DW-1:0]       min_q, min_d, max_q, max_d;
  logic [DW-1:0]       rem_q, rem_d;
  logic [NUM_W-1:0]    quo_q, quo_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [DW-1:0]       mpl_q, mpl_d;
  logic [DW-1:0]       gain_q, gain_d, offset_q, offset_d;
  logic                en_q, en_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [DW-1:0]       span_s;
  logic [DW:0]         r_sh, r_sub;
  logic                r_ge;
  logic [NUM_W-1:0]    quo_nx;
  logic [DW-1:0]       gain_sat;
  logic [OFF_W-1:0]    diff;

  // Next-state, datapath and output computation
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    tmin_d   = tmin_q;
    tspan_d  = tspan_q;
    min_d    = min_q;
    max_d    = max_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    step_d   = step_q;
    acc_d    = acc_q;
    mpl_d    = mpl_q;
    gain_d   = gain_q;
    offset_d = offset_q;
    en_d     = en_q;
    err_d    = err_q;
    done_d   = 1'b0;

    // One restoring-divide step: shift in the next numerator bit
    span_s   = max_q - min_q;
    r_sh     = {rem_q, quo_q[NUM_W-1]};
    r_sub    = r_sh - {1'b0, span_s};
    r_ge     = (r_sh >= {1'b0, span_s});
    quo_nx   = {quo_q[NUM_W-2:0], r_ge};
    gain_sat = (quo_nx > NUM_W'(DW_MAX)) ? DW_MAX : DW'(quo_nx);

    // Offset = tmin - (P >> FRAC_W); MSB of diff is the sign
    diff = OFF_W'(tmin_q) - OFF_W'(acc_q[PROD_W-1:FRAC_W]);

    if (cal_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cal_start && !busy_q) begin
            if ((reg_cal_samples == '0) || (reg_cal_target_max <= reg_cal_target_min)) begin
              err_d = 1'b1;
            end else begin
              err_d   = 1'b0;
              state_d = S_MEASURE;
              n_d     = reg_cal_samples;
              tmin_d  = reg_cal_target_min;
              tspan_d = reg_cal_target_max - reg_cal_target_min;
              min_d   = DW_MAX;
              max_d   = '0;
              cnt_d   = '0;
            end
          end
        end
        S_MEASURE: begin
          if (adc_data_in_vld) begin
            if (adc_data_in < min_q) min_d = adc_data_in;
            if (adc_data_in > max_q) max_d = adc_data_in;
            cnt_d = cnt_q + CNT_W'(1);
            if ((cnt_q + CNT_W'(1)) == n_q) begin
              state_d = S_DIV;
              quo_d   = {tspan_q, {FRAC_W{1'b0}}};
              rem_d   = '0;
              step_d  = '0;
            end
          end
        end
        S_DIV: begin
          if (span_s == '0) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            rem_d  = DW'(r_ge ? r_sub : r_sh);
            quo_d  = quo_nx;
            step_d = step_q + STEP_W'(1);
            if (step_q == STEP_W'(NUM_W - 1)) begin
              state_d = S_MUL;
              step_d  = '0;
              acc_d   = '0;
              mpl_d   = gain_sat;
            end
          end
        end
        S_MUL: begin
          // MSB-first shift-add; rotating the multiplier leaves the gain
          // intact after DW steps, ready for publishing
          acc_d  = {acc_q[PROD_W-2:0], 1'b0} + (mpl_q[DW-1] ? PROD_W'(min_q) : PROD_W'(0));
          mpl_d  = {mpl_q[DW-2:0], mpl_q[DW-1]};
          step_d = step_q + STEP_W'(1);
          if (step_q == STEP_W'(DW - 1)) state_d = S_APPLY;
        end
        S_APPLY: begin
          gain_d = mpl_q;
          if (diff[OFF_W-1])                offset_d = '0;
          else if (diff > OFF_W'(DW_MAX))   offset_d = DW_MAX;
          else                              offset_d = DW'(diff);
          en_d    = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Busy covers the done cycle so consumers see done while busy is high
    busy_d = (state_d != S_IDLE) || done_d;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      cnt_q    <= '0;
      tmin_q   <= '0;
      tspan_q  <= '0;
      min_q    <= DW_MAX;
      max_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      step_q   <= '0;
      acc_q    <= '0;
      mpl_q    <= '0;
      gain_q   <= GAIN_ONE;
      offset_q <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      tmin_q   <= tmin_d;
      tspan_q  <= tspan_d;
      min_q    <= min_d;
      max_q    <= max_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      mpl_q    <= mpl_d;
      gain_q   <= gain_d;
      offset_q <= offset_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cal_gain   = gain_q;
  assign cal_offset = offset_q;
  assign cal_en     = en_q;
  assign cal_busy   = busy_q;
  assign cal_done   = done_q;
  assign cal_err    = err_q;

endmodule

// File: tb/tb_dds_cal_engine.sv
// Testbench for dds_cal_engine: directed calibration runs checked every
// cycle against a behavioural expectation of all six outputs, plus literal
// expectations for the documented scenarios.
`timescale 1ns/1ps
module tb_dds_cal_engine;

  localparam int unsigned DW    = 14;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cal_start, cal_abort;
  logic [CNT_W-1:0] reg_cal_samples;
  logic [DW-1:0]    reg_cal_target_min, reg_cal_target_max;
  logic [DW-1:0]    adc_data_in;
  logic             adc_data_in_vld;
  logic [DW-1:0]    cal_gain, cal_offset;
  logic             cal_en, cal_busy, cal_done, cal_err;

  int n_vec = 0;
  int n_bad = 0;

  // Expected output state, maintained by the stimulus
  int exp_gain = 8192, exp_off = 0;
  bit exp_en = 0, exp_busy = 0, exp_done = 0, exp_err = 0;

  int smp_q[$];

  dds_cal_engine #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .cal_start          (cal_start),
    .cal_abort          (cal_abort),
    .reg_cal_samples    (reg_cal_samples),
    .reg_cal_target_min (reg_cal_target_min),
    .reg_cal_target_max (reg_cal_target_max),
    .adc_data_in        (adc_data_in),
    .adc_data_in_vld    (adc_data_in_vld),
    .cal_gain           (cal_gain),
    .cal_offset         (cal_offset),
    .cal_en             (cal_en),
    .cal_busy           (cal_busy),
    .cal_done           (cal_done),
    .cal_err            (cal_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp_v);
    end
  endtask

  // Model: gain = min((T<<13)/S, 0x3FFF); offset = clamp(tmin - min*gain/8192)
  function automatic int model_gain(input int s, input int t);
    int q;
    q = (t * 8192) / s;
    return (q > 16383) ? 16383 : q;
  endfunction

  function automatic int model_off(input int mn, input int g, input int tmin);
    int o;
    o = tmin - ((mn * g) / 8192);
    if (o < 0) o = 0;
    if (o > 16383) o = 16383;
    return o;
  endfunction

  // Per-cycle compare of every output against the expected state
  always @(negedge clk) begin
    check("gain",   32'(cal_gain),   32'(exp_gain));
    check("offset", 32'(cal_offset), 32'(exp_off));
    check("en",     32'(cal_en),     32'(exp_en));
    check("busy",   32'(cal_busy),   32'(exp_busy));
    check("done",   32'(cal_done),   32'(exp_done));
    check("err",    32'(cal_err),    32'(exp_err));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid_cycle();
    #2 rst = 1'b0;
    #1;
    check("rst_gain",   32'(cal_gain),   32'h2000);
    check("rst_offset", 32'(cal_offset), 32'd0);
    check("rst_en",     32'(cal_en),     32'd0);
    check("rst_busy",   32'(cal_busy),   32'd0);
    check("rst_done",   32'(cal_done),   32'd0);
    check("rst_err",    32'(cal_err),    32'd0);
    exp_gain = 8192; exp_off = 0; exp_en = 0;
    exp_busy = 0; exp_done = 0; exp_err = 0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // One calibration run using smp_q; abort_at/reset_at count edges after
  // the final sample (0 = not used)
  task automatic do_run(input int n, input int tmin, input int tmax, input bit gaps,
                        input int abort_at, input bit mid_start, input int reset_at);
    int mn, mx, g, o;
    reg_cal_samples    = CNT_W'(n);
    reg_cal_target_min = DW'(tmin);
    reg_cal_target_max = DW'(tmax);
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    if (n == 0 || tmax <= tmin) begin
      exp_err = 1;
      return;
    end
    exp_err  = 0;
    exp_busy = 1;
    mn = 16383;
    mx = 0;
    foreach (smp_q[i]) begin
      if (gaps) begin
        adc_data_in     = 14'd100;
        adc_data_in_vld = 1'b0;
        tick();
      end
      if (mid_start && i == 1) begin
        cal_start          = 1'b1;
        reg_cal_samples    = 16'd2;
        reg_cal_target_min = 14'd0;
        reg_cal_target_max = 14'd8000;
      end
      adc_data_in     = DW'(smp_q[i]);
      adc_data_in_vld = 1'b1;
      tick();
      adc_data_in_vld = 1'b0;
      cal_start       = 1'b0;
      if (smp_q[i] < mn) mn = smp_q[i];
      if (smp_q[i] > mx) mx = smp_q[i];
    end
    if (mx == mn) begin
      tick();
      exp_err  = 1;
      exp_busy = 0;
      return;
    end
    g = model_gain(mx - mn, tmax - tmin);
    o = model_off(mn, g, tmin);
    for (int c = 1; c <= 41; c++) begin
      if (c == abort_at) cal_abort = 1'b1;
      tick();
      cal_abort = 1'b0;
      if (c == abort_at) begin
        exp_busy = 0;
        return;
      end
      if (c == reset_at) begin
        reset_mid_cycle();
        return;
      end
    end
    tick();
    exp_gain = g; exp_off = o; exp_en = 1; exp_done = 1;
    tick();
    exp_done = 0; exp_busy = 0;
  endtask

  initial begin
    cal_start          = 1'b0;
    cal_abort          = 1'b0;
    reg_cal_samples    = '0;
    reg_cal_target_min = '0;
    reg_cal_target_max = '0;
    adc_data_in        = '0;
    adc_data_in_vld    = 1'b0;

    tick();
    tick();
    check("init_gain", 32'(cal_gain), 32'h2000);
    check("init_busy", 32'(cal_busy), 32'd0);
    rst = 1'b1;
    tick();

    // Pin the model with hand-computed values
    check("pin_unity_gain", 32'(model_gain(8000, 8000)), 32'h2000);
    check("pin_1p5_gain",   32'(model_gain(4000, 6000)), 32'h3000);
    check("pin_sat_off",    32'(model_off(4000, 16383, 0)), 32'd0);

    // Unity run
    smp_q = {1000, 9000, 5000, 3000};
    do_run(4, 2000, 10000, 0, 0, 0, 0);
    check("unity_gain", 32'(cal_gain),   32'h2000);
    check("unity_off",  32'(cal_offset), 32'd1000);
    check("unity_en",   32'(cal_en),     32'd1);

    // Gain 1.5
    smp_q = {4000, 8000};
    do_run(2, 7000, 13000, 0, 0, 0, 0);
    check("g15_gain", 32'(cal_gain),   32'h3000);
    check("g15_off",  32'(cal_offset), 32'd1000);

    // Saturation and clamp
    do_run(2, 0, 8000, 0, 0, 0, 0);
    check("sat_gain", 32'(cal_gain),   32'h3fff);
    check("sat_off",  32'(cal_offset), 32'd0);

    // Zero span error
    smp_q = {5000, 5000, 5000};
    do_run(3, 2000, 10000, 0, 0, 0, 0);
    tick();
    check("zspan_err",  32'(cal_err),  32'd1);
    check("zspan_gain", 32'(cal_gain), 32'h3fff);

    // Rejected starts
    do_run(0, 2000, 10000, 0, 0, 0, 0);
    tick();
    do_run(2, 5000, 5000, 0, 0, 0, 0);
    tick();
    check("rej_err",  32'(cal_err),  32'd1);
    check("rej_busy", 32'(cal_busy), 32'd0);

    // Gapped valid, clears err
    smp_q = {3000, 6000, 2000, 7000, 4000, 5000, 2500, 6500};
    do_run(8, 4000, 12000, 1, 0, 0, 0);
    check("gap_gain", 32'(cal_gain),   32'd13107);
    check("gap_off",  32'(cal_offset), 32'd801);
    check("gap_err",  32'(cal_err),    32'd0);

    // Abort in DIV
    do_run(8, 5000, 13000, 1, 10, 0, 0);
    tick();
    check("abort_off", 32'(cal_offset), 32'd801);

    // Start mid-run ignored
    do_run(8, 5000, 13000, 1, 0, 1, 0);
    check("midstart_gain", 32'(cal_gain),   32'd13107);
    check("midstart_off",  32'(cal_offset), 32'd1801);

    // Reset during MUL, then fresh unity run
    smp_q = {1000, 9000, 5000, 3000};
    do_run(4, 2000, 10000, 0, 0, 0, 33);
    tick();
    do_run(4, 2000, 10000, 0, 0, 0, 0);
    check("post_rst_gain", 32'(cal_gain),   32'h2000);
    check("post_rst_off",  32'(cal_offset), 32'd1000);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
